// File: rtl/accel_axis_sequencer.sv
//==============================================================================
// accel_axis_sequencer
// Sequences setup and round-robin X/Y/Z reads for the SPI accelerometer
// controller and publishes coherent {X,Y,Z} samples.
// Revision: 1.0
//==============================================================================
`default_nettype none

module accel_axis_sequencer #(
    parameter int DWELL_CYCLES = 131072,
    parameter int GAP_CYCLES   = 32768,
    parameter int CNT_W        = 20
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       ENABLE,
    input  logic       DONE_SETUP,
    input  logic [7:0] DATA_OUT,
    output logic [3:0] OPERATION,
    output logic [7:0] X_DATA,
    output logic [7:0] Y_DATA,
    output logic [7:0] Z_DATA,
    output logic       SAMPLE_VALID,
    output logic       BUSY
);

    typedef enum logic [1:0] {
        ST_SETUP     = 2'd0,
        ST_GAP       = 2'd1,
        ST_IDLE_WAIT = 2'd2,
        ST_READ      = 2'd3
    } state_t;

    localparam logic [1:0] AXIS_X = 2'd0;
    localparam logic [1:0] AXIS_Y = 2'd1;
    localparam logic [1:0] AXIS_Z = 2'd2;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

    localparam logic [3:0] OP_SETUP = 4'b1000;
    localparam logic [3:0] OP_IDLE  = 4'b0000;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       axis;
    logic [7:0]       shadow_x;
    logic [7:0]       shadow_y;
    logic [7:0]       shadow_z;
    logic             publish;

    function automatic logic [3:0] axis_code(input logic [1:0] a);
        case (a)
            AXIS_X:  axis_code = 4'b0001;
            AXIS_Y:  axis_code = 4'b0010;
            default: axis_code = 4'b0100;
        endcase
    endfunction

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= ST_SETUP;
            cnt          <= '0;
            axis         <= AXIS_X;
            shadow_x     <= 8'h00;
            shadow_y     <= 8'h00;
            shadow_z     <= 8'h00;
            publish      <= 1'b0;
            OPERATION    <= OP_SETUP;
            X_DATA       <= 8'h00;
            Y_DATA       <= 8'h00;
            Z_DATA       <= 8'h00;
            SAMPLE_VALID <= 1'b0;
            BUSY         <= 1'b1;
        end else begin
            // A completed Z capture publishes the whole shadow set one edge later.
            SAMPLE_VALID <= publish;
            publish      <= 1'b0;
            if (publish) begin
                X_DATA <= shadow_x;
                Y_DATA <= shadow_y;
                Z_DATA <= shadow_z;
            end

            if (state != ST_SETUP && !DONE_SETUP) begin
                // Controller was reset: restart setup and drop any partial sample.
                state     <= ST_SETUP;
                cnt       <= '0;
                axis      <= AXIS_X;
                shadow_x  <= 8'h00;
                shadow_y  <= 8'h00;
                shadow_z  <= 8'h00;
                OPERATION <= OP_SETUP;
                BUSY      <= 1'b1;
            end else begin
                case (state)
                    ST_SETUP: begin
                        if (DONE_SETUP) begin
                            state     <= ST_GAP;
                            cnt       <= '0;
                            axis      <= AXIS_X;
                            OPERATION <= OP_IDLE;
                        end
                    end
                    ST_GAP: begin
                        if (cnt == GAP_LAST) begin
                            cnt <= '0;
                            if (ENABLE) begin
                                state     <= ST_READ;
                                OPERATION <= axis_code(axis);
                            end else begin
                                state <= ST_IDLE_WAIT;
                                BUSY  <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_IDLE_WAIT: begin
                        if (ENABLE) begin
                            state <= ST_GAP;
                            cnt   <= '0;
                            BUSY  <= 1'b1;
                        end
                    end
                    ST_READ: begin
                        if (cnt == DWELL_LAST) begin
                            case (axis)
                                AXIS_X:  shadow_x <= DATA_OUT;
                                AXIS_Y:  shadow_y <= DATA_OUT;
                                default: shadow_z <= DATA_OUT;
                            endcase
                            publish   <= (axis == AXIS_Z);
                            axis      <= (axis == AXIS_Z) ? AXIS_X : axis + 2'd1;
                            state     <= ST_GAP;
                            cnt       <= '0;
                            OPERATION <= OP_IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/accel_axis_sequencer.md
# accel_axis_sequencer

Control stage directly upstream of the SPI accelerometer controller.
- Drives the controller's one-hot `OPERATION` bus: first the register-setup sequence, then round-robin X/Y/Z register reads.
- Samples the controller's `DATA_OUT` byte after each read window and assembles a coherent {X,Y,Z} sample.
- Inserts an idle gap between axes so the controller leaves its burst-read loop and re-issues instruction/address for the next axis.

## Interface
Parameters:
- `DWELL_CYCLES`, 131072: CLK cycles `OPERATION` is held on one axis before `DATA_OUT` is captured. Must cover one 24-bit read transaction at SCLK ≈ 51 kHz.
- `GAP_CYCLES`, 32768: CLK cycles `OPERATION` is held at 4'b0000 between axes. Must cover completion of an in-flight 8-bit read byte.
- `CNT_W`, 20: width of the dwell/gap counter. Must hold max(`DWELL_CYCLES`, `GAP_CYCLES`).

Ports:
- `CLK` input 1: 125 MHz system clock.
- `RESET_N` input 1: reset, asynchronous, active-low.
- `ENABLE` input 1: permits sampling; checked only at gap end.
- `DONE_SETUP` input 1: from the SPI controller; high once setup writes are finished.
- `DATA_OUT` input 8: last byte read by the SPI controller.
- `OPERATION` output 4: one-hot command to the controller. 4'b1000 = setup, 4'b0001 = X, 4'b0010 = Y, 4'b0100 = Z, 4'b0000 = idle.
- `X_DATA` output 8: latest captured X byte.
- `Y_DATA` output 8: latest captured Y byte.
- `Z_DATA` output 8: latest captured Z byte.
- `SAMPLE_VALID` output 1: one-cycle pulse when X/Y/Z all hold a new, consistent sample.
- `BUSY` output 1: high in every state except `IDLE_WAIT`.

## Operation
States:
- `SETUP`: reset state. `OPERATION`=4'b1000. When `DONE_SETUP`=1 is sampled, go to `GAP`; counter cleared and axis pointer set to X.
- `GAP`: `OPERATION`=4'b0000. Counter increments each cycle. At counter == `GAP_CYCLES`-1:
  - `ENABLE`=1: go to `READ`, counter cleared.
  - `ENABLE`=0: go to `IDLE_WAIT`.
- `IDLE_WAIT`: `OPERATION`=4'b0000, `BUSY`=0. On `ENABLE`=1, go to `GAP` with counter cleared. A full gap always precedes a read.
- `READ`: `OPERATION` = one-hot code of the axis pointer. Counter increments each cycle. At counter == `DWELL_CYCLES`-1:
  - Capture `DATA_OUT` into the shadow register for the current axis.
  - Advance pointer X→Y→Z→X.
  - Go to `GAP`, counter cleared.
- Sample assembly:
  - X, Y and Z captures go to shadow registers.
  - On the Z capture cycle, all three shadows are copied to `X_DATA`/`Y_DATA`/`Z_DATA` on the next edge and `SAMPLE_VALID` pulses high for exactly that one cycle.
  - `X_DATA`/`Y_DATA`/`Z_DATA` therefore never show a mixed-sample set.
- `DONE_SETUP` falling while outside `SETUP` (controller reset): go to `SETUP`, pointer to X, shadows discarded, outputs keep their last values.
- `ENABLE` falling mid-`READ`: the current axis completes. The sequence pauses only at the next gap end. A partial X/Y set is kept in the shadows and continues on resume; pointer is not reset.
- Counter never wraps: it is cleared on every state transition. `CNT_W` must hold max(`DWELL_CYCLES`, `GAP_CYCLES`)-1.

## Timing
- Reset values:
  - State = `SETUP`.
  - `OPERATION`=4'b1000.
  - `X_DATA`/`Y_DATA`/`Z_DATA`=8'h00.
  - `SAMPLE_VALID`=0.
  - `BUSY`=1.
  - Counter = 0, pointer = X, shadows = 0.
- `RESET_N` low takes effect immediately, including mid-`READ` or mid-`GAP`. Release is synchronous to the next `CLK` edge.
- All outputs are registered. `OPERATION` changes on the same edge as the state change.
- `DONE_SETUP` high at edge n: `OPERATION`=4'b0000 after edge n.
- Entering `READ` at edge t: capture on edge t+`DWELL_CYCLES`. `OPERATION`=0 from that same edge.
- Full-sample period = 3·(`DWELL_CYCLES`+`GAP_CYCLES`) cycles.
- `SAMPLE_VALID` is asserted one cycle after the Z capture edge, for one cycle.
- Simultaneous `DONE_SETUP` fall and dwell end: the `SETUP` transition wins; no capture, no `SAMPLE_VALID`.

## Test plan
Bench uses `DWELL_CYCLES`=20, `GAP_CYCLES`=8, and a behavioural SPI model that returns 8'h11/8'h22/8'h33 for X/Y/Z.

- Reset then `DONE_SETUP`=0 for 100 cycles → `OPERATION` stays 4'b1000, `SAMPLE_VALID`=0, data outputs 8'h00.
- `DONE_SETUP`↑ with `ENABLE`=1 → `OPERATION` sequence is 0000(8 cycles), 0001(20), 0000(8), 0010(20), 0000(8), 0100(20). After this, `X_DATA`/`Y_DATA`/`Z_DATA` = 8'h11/8'h22/8'h33 and `SAMPLE_VALID` pulses once, exactly 1 cycle wide.
- Steady run for 5 samples → `SAMPLE_VALID` pulses spaced exactly 84 cycles apart.
- `ENABLE`↓ during Y read → Y completes, then `OPERATION`=0 and `BUSY`=0. `ENABLE`↑ 50 cycles later → gap of 8 cycles, then Z read. `SAMPLE_VALID` fires with the X value captured before the pause.
- `DONE_SETUP`↓ during Z dwell → no `SAMPLE_VALID`, `OPERATION`=4'b1000 next cycle, data outputs keep the previous sample.
- `RESET_N`↓ mid-`READ` → all outputs at reset values within the same cycle, without waiting for a `CLK` edge.
